// File: rtl/lanzones_mem_pkg.sv
// lanzones_mem_pkg: shared types and widths for the lanzones memory master.
package lanzones_mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // One queued bus command as the core hands it over.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    // Bus sequencer states; GAP is the mandatory idle cycle after each response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/lanzones_mem_if.sv
// lanzones_mem_if: command/response handshake from the core plus the
// word-addressed memory bus towards the responder.
//
// Handshakes:
//   command  - a command moves on every rising edge where cmd_valid && cmd_ready;
//              cmd_we/cmd_addr/cmd_wdata must be stable while cmd_valid is high.
//   response - rsp_valid is a one-cycle pulse with no backpressure; rsp_we,
//              rsp_rdata and rsp_err are meaningful only while it is high.
//   bus      - RRdy holds the request (RAddr/RWEn/RWData stable) until RVld is
//              sampled high; RData is valid only while RVld = 1.
interface lanzones_mem_if;
    import lanzones_mem_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              RRdy;
    logic [ADDR_W-1:0] RAddr;
    logic              RWEn;
    logic [DATA_W-1:0] RWData;
    logic              RVld;
    logic [DATA_W-1:0] RData;

    // The memory master itself.
    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, RVld, RData,
        output cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
        output RRdy, RAddr, RWEn, RWData
    );

    // The surroundings: core command source/response sink and the responder.
    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, RVld, RData,
        input  cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
        input  RRdy, RAddr, RWEn, RWData
    );

endinterface

// File: rtl/lanzones_cmd_fifo.sv
// lanzones_cmd_fifo: small synchronous command FIFO. Pointers carry one extra
// wrap bit so full and empty are distinguishable; the head is read straight
// out of the storage registers.
module lanzones_cmd_fifo
    import lanzones_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t din,
    input  logic pop,
    output cmd_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push while full is refused even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage write; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update; push and pop in one cycle are both honoured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/lanzones_mem_master.sv
// lanzones_mem_master: buffers core read/write commands and issues them one at
// a time on the lanzones memory bus, returning one in-order response each.
// Optional feature macro: LANZONES_MEM_TIMEOUT_EN adds a REQ-phase timeout
// that aborts a command with rsp_err = 1 after TIMEOUT cycles without RVld.
module lanzones_mem_master
    import lanzones_mem_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    lanzones_mem_if.master mif,
    output logic           busy,
    output state_t         dbg_state
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lanzones_mem_master: DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("lanzones_mem_master: TIMEOUT must lie in 2..65535");
    end

    cmd_t              cmd_in;
    cmd_t              head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    state_t            state;
    logic              rrdy_q;
    logic              rwen_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [DATA_W-1:0] rwdata_q;
    logic              rsp_valid_q;
    logic              rsp_we_q;
    logic [DATA_W-1:0] rsp_rdata_q;

`ifdef LANZONES_MEM_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0]       to_cnt;
    logic              rsp_err_q;
`endif

    assign cmd_in = '{we: mif.cmd_we, addr: mif.cmd_addr, wdata: mif.cmd_wdata};

    // The head leaves the FIFO on the same edge it is launched onto the bus.
    assign pop = (state == IDLE) && !fifo_empty;

    lanzones_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (mif.cmd_valid),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Bus sequencer: launch from IDLE, hold in REQ until RVld (or timeout), one GAP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rrdy_q      <= 1'b0;
            rwen_q      <= 1'b0;
            raddr_q     <= '0;
            rwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef LANZONES_MEM_TIMEOUT_EN
            to_cnt      <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef LANZONES_MEM_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        rrdy_q   <= 1'b1;
                        rwen_q   <= head.we;
                        raddr_q  <= head.addr;
                        rwdata_q <= head.wdata;
`ifdef LANZONES_MEM_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                        state    <= REQ;
                    end
                end
                REQ: begin
                    // RVld takes priority over a timeout on the same edge.
                    if (mif.RVld) begin
                        rrdy_q      <= 1'b0;
                        rwen_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_we_q    <= rwen_q;
                        rsp_rdata_q <= rwen_q ? '0 : mif.RData;
                        state       <= GAP;
                    end
`ifdef LANZONES_MEM_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        rrdy_q      <= 1'b0;
                        rwen_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_we_q    <= rwen_q;
                        rsp_err_q   <= 1'b1;
                        state       <= GAP;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mif.cmd_ready = !fifo_full;
    assign mif.RRdy      = rrdy_q;
    assign mif.RWEn      = rwen_q;
    assign mif.RAddr     = raddr_q;
    assign mif.RWData    = rwdata_q;
    assign mif.rsp_valid = rsp_valid_q;
    assign mif.rsp_we    = rsp_we_q;
    assign mif.rsp_rdata = rsp_rdata_q;
`ifdef LANZONES_MEM_TIMEOUT_EN
    assign mif.rsp_err   = rsp_err_q;
`else
    assign mif.rsp_err   = 1'b0;
`endif

    assign busy      = !fifo_empty || (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_lanzones_mem_master.sv
// tb_lanzones_mem_master: randomized and directed bench for lanzones_mem_master
// with a behavioural responder and a command-order scoreboard.
module tb_lanzones_mem_master;
    import lanzones_mem_pkg::*;

    localparam int DEPTH      = 4;
    localparam int TB_TIMEOUT = 8;
    localparam int W          = 34;   // {err, we, rdata}

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   busy;
    state_t dbg_state;

    lanzones_mem_if mif();

    lanzones_mem_master #(.DEPTH(DEPTH), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .mif       (mif.master),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- memory contents ----------------
    logic [31:0] resp_mem  [logic [31:0]];
    logic [31:0] model_mem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] resp_word(input logic [31:0] a);
        return resp_mem.exists(a) ? resp_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction

    // ---------------- responder: RVld one edge after it samples RRdy ----------------
    // Addresses with bit 31 set model a dead region that never answers.
    logic spur = 1'b0;

    initial begin
        logic        r, w, nv;
        logic [31:0] a, d;
        mif.RVld  = 1'b0;
        mif.RData = '0;
        forever begin
            @(negedge clk);
            r = mif.RRdy; w = mif.RWEn; a = mif.RAddr; d = mif.RWData;
            @(posedge clk);
            #1;
            if (rst) begin
                mif.RVld  = 1'b0;
                mif.RData = '0;
            end else begin
                if (w) resp_mem[a] = d;
                nv = spur || (r && !mif.RVld && !a[31]);
                spur = 1'b0;
                mif.RData = (nv && r) ? resp_word(a) : 32'h0;
                mif.RVld  = nv;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           accept_cyc[$];
    int           rise_cyc[$];
    int           last_rise = 0;
    int           rsp_cnt   = 0;
    logic         rrdy_prev = 1'b0;

    always @(negedge clk) begin
        logic [W-1:0] e;
        int           lat;
        if (rst) begin
            rrdy_prev = 1'b0;
        end else begin
            if (mif.cmd_valid && mif.cmd_ready) begin
                accept_cyc.push_back(cyc + 1);
                if (mif.cmd_we) begin
                    model_mem[mif.cmd_addr] = mif.cmd_wdata;
                    exp_q.push_back({1'b0, 1'b1, 32'h0});
                end
`ifdef LANZONES_MEM_TIMEOUT_EN
                else if (mif.cmd_addr[31]) begin
                    exp_q.push_back({1'b1, 1'b0, 32'h0});
                end
`endif
                else begin
                    exp_q.push_back({1'b0, 1'b0, model_word(mif.cmd_addr)});
                end
            end
            if (mif.RRdy && !rrdy_prev) begin
                last_rise = cyc;
                rise_cyc.push_back(cyc);
            end
            rrdy_prev = mif.RRdy;
            check("rwen_without_rrdy", 64'(mif.RWEn && !mif.RRdy), 64'(0));
            if (mif.rsp_valid) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    lat = e[33] ? TB_TIMEOUT : 2;
                    check("rsp_err",   64'(mif.rsp_err),   64'(e[33]));
                    check("rsp_we",    64'(mif.rsp_we),    64'(e[32]));
                    check("rsp_rdata", 64'(mif.rsp_rdata), 64'(e[31:0]));
                    check("rsp_latency", 64'(cyc - last_rise), 64'(lat));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called one time unit after a rising edge; returns one unit after the accepting edge.
    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int n = 0;
        mif.cmd_valid = 1'b1;
        mif.cmd_we    = we;
        mif.cmd_addr  = addr;
        mif.cmd_wdata = wd;
        @(negedge clk);
        while (!mif.cmd_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("cmd_accept_wait", 64'(mif.cmd_ready), 64'(1));
        @(posedge clk);
        #1;
        mif.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("drain_done", 64'(exp_q.size() == 0 && !busy), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rrdy();
        int n = 0;
        @(negedge clk);
        while (!mif.RRdy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("wait_rrdy", 64'(mif.RRdy), 64'(1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc_off[6];
        int n;
        acc_off = '{0, 1, 2, 3, 4, 6};
        mif.cmd_valid = 1'b0;
        mif.cmd_we    = 1'b0;
        mif.cmd_addr  = '0;
        mif.cmd_wdata = '0;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rrdy",      64'(mif.RRdy),      64'(0));
        check("rst_rwen",      64'(mif.RWEn),      64'(0));
        check("rst_raddr",     64'(mif.RAddr),     64'(0));
        check("rst_rwdata",    64'(mif.RWData),    64'(0));
        check("rst_rsp_valid", 64'(mif.rsp_valid), 64'(0));
        check("rst_rsp_we",    64'(mif.rsp_we),    64'(0));
        check("rst_rsp_err",   64'(mif.rsp_err),   64'(0));
        check("rst_rsp_rdata", 64'(mif.rsp_rdata), 64'(0));
        check("rst_busy",      64'(busy),          64'(0));
        check("rst_cmd_ready", 64'(mif.cmd_ready), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single read of the preloaded word
        send(1'b0, 32'h100, 32'h0);
        drain();

        // write then read back in order
        send(1'b1, 32'h101, 32'h12345678);
        send(1'b0, 32'h101, 32'h0);
        drain();

        // back-to-back burst: FIFO fills, RRdy rises every 4 cycles
        @(posedge clk);
        #1;
        accept_cyc.delete();
        rise_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            send(1'(i % 2), 32'h180 + 32'(i), $urandom);
            if (i == 4) check("burst_full_ready", 64'(mif.cmd_ready), 64'(0));
        end
        drain();
        check("burst_accept_count", 64'(accept_cyc.size()), 64'(6));
        check("burst_rise_count",   64'(rise_cyc.size()),   64'(6));
        for (int k = 0; k < 6 && k < accept_cyc.size() && k < rise_cyc.size(); k++) begin
            check("burst_accept_cycle", 64'(accept_cyc[k] - accept_cyc[0]), 64'(acc_off[k]));
            check("burst_rise_cycle",   64'(rise_cyc[k] - accept_cyc[0]),   64'(1 + 4 * k));
        end

        // asynchronous reset while a read is in REQ
        send(1'b0, 32'h100, 32'h0);
        wait_rrdy();
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("mid_rst_rrdy",      64'(mif.RRdy),      64'(0));
        check("mid_rst_rwen",      64'(mif.RWEn),      64'(0));
        check("mid_rst_rsp_valid", 64'(mif.rsp_valid), 64'(0));
        check("mid_rst_busy",      64'(busy),          64'(0));
        check("mid_rst_cmd_ready", 64'(mif.cmd_ready), 64'(1));
        check("mid_rst_state",     64'(dbg_state),     64'(IDLE));
        n = rsp_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("rst_lost_no_rsp", 64'(rsp_cnt - n), 64'(0));
        send(1'b0, 32'h101, 32'h0);
        drain();

        // spurious RVld while idle
        n = rsp_cnt;
        spur = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("spur_state",  64'(dbg_state),     64'(IDLE));
        check("spur_busy",   64'(busy),          64'(0));
        check("spur_no_rsp", 64'(rsp_cnt - n),   64'(0));

`ifdef LANZONES_MEM_TIMEOUT_EN
        // dead address times out, the queued read behind it then issues
        send(1'b0, 32'h80000010, 32'h0);
        send(1'b0, 32'h100, 32'h0);
        drain();
`endif

        // randomized traffic over a small address window
        for (int i = 0; i < 40; i++) begin
            int gap;
            send(1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 7)), $urandom);
            gap = int'($urandom_range(0, 3));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
